// File: rtl/grf_wa_pipe_if.sv
// D-stage write-address / hazard bus between decoder, pipe tracker and stall/forward muxes.
// master drives the D-stage fields; slave returns the tracked stages and hazard results.
interface grf_wa_pipe_if #(
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int NSTAGE = 3
);
  localparam int SW = $clog2(NSTAGE + 1);

  logic [1:0]           sel_wa;
  logic [AW-1:0]        instr_rt;
  logic [AW-1:0]        instr_rd;
  logic [TW-1:0]        tnew_in;
  logic                 stall;
  logic                 flush;
  logic [AW-1:0]        rs_addr;
  logic [AW-1:0]        rt_addr;
  logic [TW-1:0]        tuse_rs;
  logic [TW-1:0]        tuse_rt;
  logic [AW-1:0]        wa_d;
  logic [NSTAGE*AW-1:0] stage_wa;
  logic [NSTAGE*TW-1:0] stage_tnew;
  logic                 stall_req;
  logic [SW-1:0]        fwd_rs;
  logic [SW-1:0]        fwd_rt;

  modport master (
    output sel_wa, instr_rt, instr_rd, tnew_in, stall, flush,
           rs_addr, rt_addr, tuse_rs, tuse_rt,
    input  wa_d, stage_wa, stage_tnew, stall_req, fwd_rs, fwd_rt
  );

  modport slave (
    input  sel_wa, instr_rt, instr_rd, tnew_in, stall, flush,
           rs_addr, rt_addr, tuse_rs, tuse_rt,
    output wa_d, stage_wa, stage_tnew, stall_req, fwd_rs, fwd_rt
  );
endinterface

// File: rtl/grf_wa_pipe.sv
// Write-address select plus {wa, tnew} tracking over NSTAGE stages; stage k valid k+1 cycles after D.
// No backpressure: stall/flush only insert a bubble into stage 0, later stages always advance.
module grf_wa_pipe #(
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int NSTAGE   = 3,
  parameter int LINK_REG = 31
) (
  input logic             clk,
  input logic             reset,
  grf_wa_pipe_if.slave    bus
);
  localparam int SW = $clog2(NSTAGE + 1);

  logic [AW-1:0] wa_sel;
  logic [AW-1:0] wa_q   [NSTAGE];
  logic [TW-1:0] tnew_q [NSTAGE];
  logic          hazard_rs, hazard_rt;
  logic [SW-1:0] fwd_rs_c, fwd_rt_c;

  always_comb begin
    wa_sel = '0;
    case (bus.sel_wa)
      2'b00:   wa_sel = bus.instr_rt;
      2'b01:   wa_sel = bus.instr_rd;
      2'b10:   wa_sel = AW'(LINK_REG);
      default: wa_sel = '0;
    endcase
  end

  // Address 0 means "no write", so its tnew is forced to 0 and never ages into a false hazard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        wa_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      if (bus.stall || bus.flush) begin
        wa_q[0]   <= '0;
        tnew_q[0] <= '0;
      end else begin
        wa_q[0]   <= wa_sel;
        tnew_q[0] <= (wa_sel != '0) ? bus.tnew_in : '0;
      end
      for (int k = 1; k < NSTAGE; k++) begin
        wa_q[k]   <= wa_q[k-1];
        tnew_q[k] <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
    end
  end

  // Scan oldest to youngest so the youngest matching stage overrides older ones.
  always_comb begin
    hazard_rs = 1'b0;
    fwd_rs_c  = '0;
    hazard_rt = 1'b0;
    fwd_rt_c  = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (bus.rs_addr != '0 && wa_q[k] == bus.rs_addr) begin
        hazard_rs = (tnew_q[k] > bus.tuse_rs);
        fwd_rs_c  = (tnew_q[k] == '0) ? SW'(k + 1) : '0;
      end
      if (bus.rt_addr != '0 && wa_q[k] == bus.rt_addr) begin
        hazard_rt = (tnew_q[k] > bus.tuse_rt);
        fwd_rt_c  = (tnew_q[k] == '0) ? SW'(k + 1) : '0;
      end
    end
  end

  assign bus.wa_d      = wa_sel;
  assign bus.stall_req = hazard_rs | hazard_rt;
  assign bus.fwd_rs    = fwd_rs_c;
  assign bus.fwd_rt    = fwd_rt_c;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_pack
    assign bus.stage_wa[k*AW +: AW]   = wa_q[k];
    assign bus.stage_tnew[k*TW +: TW] = tnew_q[k];
  end
endmodule
